// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int CNT_W    = 4;  // wait-state counter width, covers 0..15
  localparam int WORD_OFS = 2;  // byte-address bits below the word index

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
endpackage

// File: rtl/dmem_array.sv
// Word storage: async clear, byte-masked synchronous write, registered read
// whose output is forced to zero when the access is rejected.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH),
  parameter int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NB-1:0]     be,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (wr_en)
        for (int b = 0; b < NB; b++)
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      if (rd_clr)     rdata <= '0;
      else if (rd_en) rdata <= mem[idx];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with WAIT_CYCLES wait states and a pipeline stall.
// Build option: define DMEM_BYTE_EN to add the req_be byte-enable port.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]        req_be,
`endif
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);
  localparam int AW = $clog2(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [3:0]        be_q, in_be;

`ifdef DMEM_BYTE_EN
  assign in_be = req_be;
`else
  assign in_be = 4'hF;
`endif

  // With zero wait states the access happens on the accept edge itself, so
  // the live request is used while idle and the latched copy otherwise.
  logic              idle, cur_we, access, is_err;
  logic [DATA_W-1:0] cur_addr, cur_wdata;
  logic [3:0]        cur_be;
  logic [1:0]        err_code;

  assign idle      = (state == IDLE);
  assign cur_we    = idle ? req_we    : we_q;
  assign cur_addr  = idle ? req_addr  : addr_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;
  assign cur_be    = idle ? in_be     : be_q;
  assign access    = (idle && req_valid && (WAIT_CYCLES == 0)) ||
                     (state == WAIT && cnt == CNT_W'(1));

  always_comb begin
    err_code = ERR_NONE;
    if (cur_addr[WORD_OFS-1:0] != '0)                err_code = ERR_MISALIGN;
    else if ((cur_addr >> (AW + WORD_OFS)) != '0)    err_code = ERR_RANGE;
  end
  assign is_err = (err_code != ERR_NONE);

  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .NB(4)) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (access && cur_we && !is_err),
    .rd_en  (access && !cur_we && !is_err),
    .rd_clr (access && is_err),
    .idx    (cur_addr[AW+WORD_OFS-1:WORD_OFS]),
    .wdata  (cur_wdata),
    .be     (cur_be),
    .rdata  (rsp_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'hF;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          be_q    <= in_be;
          cnt     <= CNT_W'(WAIT_CYCLES);
          state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (access) rsp_err <= is_err;
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state == RESP);
  assign stall     = !idle || req_valid;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a word-array model.
module tb_dmem_responder;
  localparam int DATA_W      = 32;
  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 2;
`ifdef DMEM_BYTE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
`ifdef DMEM_BYTE_EN
  logic [3:0] req_be = 4'hF;
`endif
  logic req_ready, rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;

  dmem_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_EN
    .req_be(req_be),
`endif
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .stall(stall));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        chk_rdata;
    logic        err;
    logic [31:0] rdata;
    int          due;  // posedge index at which rsp_valid is sampled
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, want);
    end
  endtask

  // Monitor: sampled mid-cycle, cyc+1 is the index of the next sampling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_stall", {31'd0, stall}, {31'd0, req_valid});
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_q.size() == 0});
      chk("stall", {31'd0, stall}, {31'd0, (exp_q.size() != 0) || req_valid});
      if (exp_q.size() != 0 && cyc + 1 >= exp_q[0].due) begin
        chk("rsp_valid_due", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
        if (exp_q[0].chk_rdata) chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        void'(exp_q.pop_front());
      end else begin
        chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
      end
    end
  end

  // Presents a request at posedge+1, waits for acceptance, records the
  // expected response, and leaves the bench just after the accept edge.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int    n;
    int    acc;
    exp_t  e;
    logic  err;
    logic [31:0] mask;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
`ifdef DMEM_BYTE_EN
    req_be = be;
`endif
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    acc = cyc + 1;
    err = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    e.err = err;
    e.due = acc + WAIT_CYCLES + 1;
    e.chk_rdata = !we || err;
    e.rdata = err ? 32'd0 : mem_m[addr / 4];
    if (we && !err) begin
      mask = 32'd0;
      for (int b = 0; b < 4; b++)
        if (!BE_EN || be[b]) mask = mask | (32'hFF << (8 * b));
      mem_m[addr / 4] = (mem_m[addr / 4] & ~mask) | (wdata & mask);
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
  endtask

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle_cycles(2);

    do_req(1'b0, 32'h00, 32'h0, 4'hF);
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);   // held through read's WAIT
    do_req(1'b0, 32'h10, 32'h0, 4'hF);
    idle_cycles(1);
    do_req(1'b1, 32'h13, 32'h12345678, 4'hF);
    do_req(1'b0, 32'h10, 32'h0, 4'hF);
    do_req(1'b0, 32'h400, 32'h0, 4'hF);
    idle_cycles(4);

    // Abort a write mid-wait with a one-cycle reset pulse.
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    rst = 1'b0;
    exp_q.delete();
    clear_model();
    @(posedge clk); #1 rst = 1'b1;
    idle_cycles(1);
    do_req(1'b0, 32'h20, 32'h0, 4'hF);
    do_req(1'b0, 32'h10, 32'h0, 4'hF);

`ifdef DMEM_BYTE_EN
    do_req(1'b1, 32'h08, 32'h11223344, 4'b1111);
    do_req(1'b1, 32'h08, 32'h00AA0000, 4'b0100);
    do_req(1'b0, 32'h08, 32'h0, 4'hF);
    do_req(1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000);
    do_req(1'b0, 32'h08, 32'h0, 4'hF);
`endif

    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      a = $urandom_range(0, 15) * 4;       // small set so reads hit writes
      if (sel == 0)      a = a | $urandom_range(1, 3);
      else if (sel == 1) a = 4 * DEPTH + $urandom_range(0, 255) * 4;
      else if (sel == 2) a = $urandom_range(0, DEPTH - 1) * 4;
      do_req($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(WAIT_CYCLES + 4);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the pipeline's data-memory port. The EX/MEM stage acts as the initiator and issues one read or write per request. This block accepts the request and services it from internal word storage after a configurable number of wait states. It returns read data with a response strobe and drives a stall signal that the pipeline uses to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.

Parameters:
- DATA_W, 32, data and address width in bits.
- DEPTH, 256, number of 32-bit words stored; must be a power of 2.
- WAIT_CYCLES, 2, wait states between request acceptance and access; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  initiator presents a request (EX/MEM mem_read or we).
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address (EX/MEM alu_result).
- req_wdata  input  32  write data (EX/MEM rt_data).
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  one-cycle strobe: access is complete.
- rsp_rdata  output  32  read data; valid only while rsp_valid=1.
- rsp_err  output  1  request was misaligned or out of range; valid with rsp_valid.
- stall  output  1  pipeline freeze request.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the wait counter clears.
  - All storage words clear to 0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0 (combinational from req_valid once idle).
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid=1 at the clock edge. Accepting latches req_we, req_addr and req_wdata, and loads the counter with WAIT_CYCLES.
  - Next state is WAIT, or RESP if WAIT_CYCLES=0.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle. When the counter is 1 at an edge, the next state is RESP.
- IDLE/WAIT to RESP transition edge:
  - The access executes: a write commits to storage, or a read latches the word into rsp_rdata.
  - rsp_err is computed for the request.
- RESP:
  - rsp_valid=1 for exactly one cycle, and req_ready=0.
  - Next state is always IDLE.
  - rsp_rdata holds until the next read completes.
- Latency: rsp_valid is asserted WAIT_CYCLES+1 cycles after the accept edge. Throughput is one request per WAIT_CYCLES+2 cycles.
- stall = (state != IDLE) || (state == IDLE && req_valid). This is combinational, so the pipeline freezes in the same cycle the request appears.
  - stall deasserts in the RESP cycle's successor; the pipeline advances on the edge ending RESP.
- Addressing:
  - Word index = req_addr[log2(DEPTH)+1:2].
  - req_addr[1:0] != 0 gives misaligned; req_addr >= 4*DEPTH gives out of range.
  - On either error: rsp_err=1, the write is suppressed, rsp_rdata=0.
- req_valid during WAIT or RESP is ignored; the initiator must hold it (stall guarantees this).
- Reset mid-operation (WAIT): the request is aborted and no write is committed. Storage clears regardless.
- A read-after-write to the same address in consecutive requests returns the new data.

Optional Feature:
DMEM_BYTE_EN
- Defined:
  - Adds input port req_be[3:0], latched on accept.
  - A write updates only the bytes whose enable bit is set; bit i controls bits 8i+7:8i.
  - req_be=0000 completes normally (rsp_valid, rsp_err=0) with storage unchanged.
  - Reads ignore req_be.
- Undefined: req_be is absent and every write is a full word.

Decomposition:
- dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the wait-counter width constant (4);
  - the word-offset constant (2);
  - the error-code constants.
- One sub-module: dmem_array, the storage with synchronous write, optional byte enables, asynchronous clear on rst=0, and a registered read. The FSM, counter and handshake stay in dmem_responder.

Test Plan:
- Reset release with no request: req_ready=1, stall=0, rsp_valid=0. Then read 0x00: rsp_valid 3 cycles after accept with rdata=0x00000000, stall high from the request cycle through RESP.
- Write 0x10 with data 0xDEADBEEF (WAIT_CYCLES=2), then read 0x10: each rsp_valid arrives 3 cycles after accept, rsp_err=0, read returns 0xDEADBEEF; a second accept is possible no earlier than 4 cycles after the first.
- Write 0x13 with data 0x12345678 (misaligned): rsp_err=1, rsp_rdata=0; a subsequent read of 0x10 still returns 0xDEADBEEF.
- Read 0x400 with DEPTH=256 (out of range): rsp_err=1, rsp_rdata=0. Then WAIT_CYCLES=0 build, read 0x10: rsp_valid 1 cycle after accept.
- Write 0x20 with data 0xCAFEF00D; pull rst low during WAIT for 1 cycle: no rsp_valid, state IDLE, and a read of 0x20 after release returns 0x00000000.
- DMEM_BYTE_EN build: write 0x08 with data 0x11223344 and be=1111, then write data 0x00AA0000 with be=0100. A read of 0x08 returns 0x11AA3344; a write with be=0000 leaves 0x11AA3344 unchanged.
